// File: rtl/instr_fetch_decode.sv
// Instruction fetch and decode front end: issues one memory read per request, waits a fixed
// latency, captures the word and presents it with registered decode fields under a valid/ready handshake.
module instr_fetch_decode #(
    parameter int MEM_LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        fetch_req,
    input  logic [63:0] pc,
    input  logic        flush,
    output logic        mem_rd,
    output logic [63:0] mem_addr,
    input  logic [31:0] mem_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] Instr31_0,
    output logic [2:0]  InstrType,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic [63:0] out_pc,
    output logic        illegal,
    output logic        fetch_busy
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        VALID
    } state_t;

    typedef struct packed {
        logic [2:0] itype;
        logic       bad;
    } dec_t;

    localparam logic [3:0] LATENCY = 4'(MEM_LATENCY);

    state_t     state;
    state_t     state_next;
    logic [3:0] count;
    logic       accept;
    logic       capture;
    dec_t       dec;

    function automatic dec_t decode(input logic [6:0] opcode);
        dec_t d;
        d.itype = 3'b111;
        d.bad   = 1'b0;
        case (opcode)
            7'b0000011, 7'b0010011, 7'b0011011,
            7'b1100111, 7'b1110011:             d.itype = 3'b000;
            7'b0100011:                         d.itype = 3'b001;
            7'b1100011:                         d.itype = 3'b010;
            7'b1101111:                         d.itype = 3'b011;
            7'b0110111, 7'b0010111:             d.itype = 3'b100;
            7'b0110011, 7'b0111011:             d.itype = 3'b111;
            default:                            d.bad   = 1'b1;
        endcase
        return d;
    endfunction

    // A new address is taken from IDLE, or straight out of VALID on a handshake (back-to-back).
    assign accept  = fetch_req && !flush &&
                     ((state == IDLE) || ((state == VALID) && out_ready));
    assign capture = (state == WAIT) && (count <= 4'd1) && !flush;
    assign dec     = decode(mem_data[6:0]);

    assign mem_rd     = (state == ISSUE);
    assign out_valid  = (state == VALID);
    assign fetch_busy = (state != IDLE);

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (fetch_req)        state_next = ISSUE;
            ISSUE:                         state_next = WAIT;
            WAIT:    if (count <= 4'd1)    state_next = VALID;
            VALID:   if (out_ready)        state_next = fetch_req ? ISSUE : IDLE;
            default:                       state_next = IDLE;
        endcase
        if (flush) state_next = IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            mem_addr <= '0;
            out_pc   <= '0;
        end else begin
            state <= state_next;
            // Counter parks at 1 on leaving WAIT; only ISSUE reloads it.
            if (state == ISSUE) begin
                count <= LATENCY;
            end else if ((state == WAIT) && (count > 4'd1)) begin
                count <= count - 4'd1;
            end
            if (accept) begin
                mem_addr <= pc;
                out_pc   <= pc;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            Instr31_0 <= '0;
            InstrType <= '0;
            rs1       <= '0;
            rs2       <= '0;
            rd        <= '0;
            illegal   <= 1'b0;
        end else if (capture) begin
            Instr31_0 <= mem_data;
            InstrType <= dec.itype;
            rs1       <= mem_data[19:15];
            rs2       <= mem_data[24:20];
            rd        <= mem_data[11:7];
            illegal   <= dec.bad;
        end
    end

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Scoreboard bench for instr_fetch_decode: three instances (latency 2, 1, 15), each with a
// memory model that drives the word only in the cycle it is due and junk otherwise.
module tb_instr_fetch_decode;

    localparam int NDUT = 3;

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  itype;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [63:0] pc;
        logic        ill;
    } exp_t;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              flush = 1'b0;
    logic              out_ready = 1'b1;
    logic [NDUT-1:0]   fetch_req = '0;
    logic [63:0]       pc = '0;

    logic [NDUT-1:0]   mem_rd;
    logic [NDUT-1:0]   out_valid;
    logic [NDUT-1:0]   illegal;
    logic [NDUT-1:0]   fetch_busy;
    logic [63:0]       mem_addr [NDUT];
    logic [63:0]       out_pc   [NDUT];
    logic [31:0]       instr    [NDUT];
    logic [2:0]        itype    [NDUT];
    logic [4:0]        rs1      [NDUT];
    logic [4:0]        rs2      [NDUT];
    logic [4:0]        rd       [NDUT];

    logic [31:0]       mem [logic [63:0]];
    exp_t              sb[$];
    int                checks = 0;
    int                failures = 0;
    int                cyc = 0;
    int                rd_pulses = 0;

    initial forever #5 clock = ~clock;
    initial forever begin
        @(posedge clock);
        cyc++;
    end

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int L = (g == 0) ? 2 : (g == 1) ? 1 : 15;
        logic [31:0] mem_data;

        instr_fetch_decode #(.MEM_LATENCY(L)) u_dut (
            .clock      (clock),
            .reset      (reset),
            .fetch_req  (fetch_req[g]),
            .pc         (pc),
            .flush      (flush),
            .mem_rd     (mem_rd[g]),
            .mem_addr   (mem_addr[g]),
            .mem_data   (mem_data),
            .out_valid  (out_valid[g]),
            .out_ready  (out_ready),
            .Instr31_0  (instr[g]),
            .InstrType  (itype[g]),
            .rs1        (rs1[g]),
            .rs2        (rs2[g]),
            .rd         (rd[g]),
            .out_pc     (out_pc[g]),
            .illegal    (illegal[g]),
            .fetch_busy (fetch_busy[g])
        );

        // Word is valid only in the cycle exactly L cycles after the mem_rd cycle.
        initial begin
            int age;
            bit active;
            age = 0;
            active = 1'b0;
            mem_data = 32'hDEAD_BEEF;
            forever begin
                @(negedge clock);
                if (reset) active = 1'b0;
                else if (mem_rd[g]) begin
                    active = 1'b1;
                    age = 0;
                end else if (active) age++;
                if (active && age == L && mem.exists(mem_addr[g])) mem_data = mem[mem_addr[g]];
                else mem_data = 32'hDEAD_BEEF;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Monitor: every valid cycle of instance 0 is compared with the queue head; pop on handshake.
    initial forever begin
        exp_t e;
        @(negedge clock);
        if (!reset) begin
            if (mem_rd[0]) rd_pulses++;
            if (out_valid[0]) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL mon_unexpected_valid actual=1 expected=0 (cycle %0d)", cyc);
                end else begin
                    e = sb[0];
                    check("mon_instr", instr[0], e.instr);
                    check("mon_type", itype[0], e.itype);
                    check("mon_rs1", rs1[0], e.rs1);
                    check("mon_rs2", rs2[0], e.rs2);
                    check("mon_rd", rd[0], e.rd);
                    check("mon_pc", out_pc[0], e.pc);
                    check("mon_illegal", illegal[0], e.ill);
                    if (out_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_valid(input int i, input int start, output int dt);
        int n;
        n = 0;
        @(negedge clock);
        while (!out_valid[i] && n < 40) begin
            @(negedge clock);
            n++;
        end
        dt = cyc - start;
    endtask

    task automatic single_fetch(input int i, input logic [63:0] addr, input int want_lat,
                                input string name, input exp_t e, input bit release_rst);
        int start;
        int dt;
        step();
        if (release_rst) reset = 1'b0;
        fetch_req[i] = 1'b1;
        pc = addr;
        start = cyc;
        if (i == 0) sb.push_back(e);
        step();
        fetch_req[i] = 1'b0;
        @(negedge clock);
        check({name, "_mem_rd"}, mem_rd[i], 1);
        check({name, "_mem_addr"}, mem_addr[i], addr);
        wait_valid(i, start, dt);
        check({name, "_latency"}, dt, want_lat);
        check({name, "_instr"}, instr[i], e.instr);
    endtask

    initial begin
        int start;
        int dt;
        int nvalid;
        mem[64'h100] = 32'hFFF1_0093;
        mem[64'h104] = 32'h0051_2423;
        mem[64'h108] = 32'h0020_8463;
        mem[64'h200] = 32'h0080_00EF;
        mem[64'h300] = 32'h0000_007F;
        mem[64'h304] = 32'h0001_22B7;
        mem[64'h400] = 32'hFFF1_0093;
        mem[64'h500] = 32'h0051_2423;
        mem[64'h600] = 32'h0001_22B7;

        // Reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_valid", out_valid[0], 0);
        check("rst_busy", fetch_busy[0], 0);
        check("rst_mem_rd", mem_rd[0], 0);
        check("rst_mem_addr", mem_addr[0], 0);
        check("rst_out_pc", out_pc[0], 0);
        check("rst_type", itype[0], 0);
        step();
        reset = 1'b0;

        // Basic I-type fetch, latency 2
        single_fetch(0, 64'h100, 4, "itype", '{32'hFFF1_0093, 3'b000, 5'd2, 5'd31, 5'd1, 64'h100, 1'b0}, 1'b0);

        // Back-to-back S then SB
        step();
        fetch_req[0] = 1'b1;
        pc = 64'h104;
        start = cyc;
        sb.push_back('{32'h0051_2423, 3'b001, 5'd2, 5'd5, 5'd8, 64'h104, 1'b0});
        step();
        step();
        pc = 64'h108;
        sb.push_back('{32'h0020_8463, 3'b010, 5'd1, 5'd2, 5'd8, 64'h108, 1'b0});
        step();
        step();
        @(negedge clock);
        check("b2b_first_valid", out_valid[0], 1);
        check("b2b_no_rd_in_hs", mem_rd[0], 0);
        step();
        fetch_req[0] = 1'b0;
        @(negedge clock);
        check("b2b_second_rd", mem_rd[0], 1);
        check("b2b_second_addr", mem_addr[0], 64'h108);
        wait_valid(0, start, dt);
        check("b2b_second_latency", dt, 8);

        // Backpressure with ignored fetch_req
        step();
        out_ready = 1'b0;
        fetch_req[0] = 1'b1;
        pc = 64'h200;
        start = cyc;
        sb.push_back('{32'h0080_00EF, 3'b011, 5'd0, 5'd8, 5'd1, 64'h200, 1'b0});
        step();
        fetch_req[0] = 1'b0;
        wait_valid(0, start, dt);
        check("bp_latency", dt, 4);
        for (int k = 0; k < 5; k++) begin
            step();
            fetch_req[0] = 1'b1;
            pc = 64'h999;
            @(negedge clock);
            check("bp_valid_held", out_valid[0], 1);
        end
        step();
        fetch_req[0] = 1'b0;
        out_ready = 1'b1;
        step();
        @(negedge clock);
        check("bp_after_hs_valid", out_valid[0], 0);
        check("bp_after_hs_busy", fetch_busy[0], 0);

        // Illegal opcode, then U-type
        single_fetch(0, 64'h300, 4, "illegal", '{32'h0000_007F, 3'b111, 5'd0, 5'd0, 5'd0, 64'h300, 1'b1}, 1'b0);
        single_fetch(0, 64'h304, 4, "utype", '{32'h0001_22B7, 3'b100, 5'd2, 5'd0, 5'd5, 64'h304, 1'b0}, 1'b0);

        // Flush in WAIT, with fetch_req held through it
        step();
        fetch_req[0] = 1'b1;
        pc = 64'h400;
        step();
        fetch_req[0] = 1'b0;
        step();
        flush = 1'b1;
        fetch_req[0] = 1'b1;
        @(negedge clock);
        check("flush_in_wait_busy", fetch_busy[0], 1);
        step();
        @(negedge clock);
        check("flush_idle_busy", fetch_busy[0], 0);
        check("flush_idle_valid", out_valid[0], 0);
        step();
        flush = 1'b0;
        fetch_req[0] = 1'b0;
        @(negedge clock);
        check("flush_wins_over_req", fetch_busy[0], 0);
        nvalid = 0;
        repeat (6) begin
            step();
            @(negedge clock);
            if (out_valid[0]) nvalid++;
        end
        check("flush_no_valid", nvalid, 0);

        // Reset while VALID
        step();
        out_ready = 1'b0;
        fetch_req[0] = 1'b1;
        pc = 64'h500;
        start = cyc;
        sb.push_back('{32'h0051_2423, 3'b001, 5'd2, 5'd5, 5'd8, 64'h500, 1'b0});
        step();
        fetch_req[0] = 1'b0;
        wait_valid(0, start, dt);
        check("rstv_latency", dt, 4);
        step();
        reset = 1'b1;
        #1;
        check("rstv_valid", out_valid[0], 0);
        check("rstv_busy", fetch_busy[0], 0);
        check("rstv_mem_addr", mem_addr[0], 0);
        check("rstv_out_pc", out_pc[0], 0);
        check("rstv_instr", instr[0], 0);
        check("rstv_type", itype[0], 0);
        check("rstv_regs", {rs1[0], rs2[0], rd[0]}, 0);
        check("rstv_illegal", illegal[0], 0);
        sb.delete();
        out_ready = 1'b1;
        step();
        reset = 1'b0;
        repeat (4) step();
        @(negedge clock);
        check("rstv_stays_idle", fetch_busy[0], 0);

        // Fetch accepted on the first edge after reset release
        step();
        reset = 1'b1;
        single_fetch(0, 64'h100, 4, "post_rst", '{32'hFFF1_0093, 3'b000, 5'd2, 5'd31, 5'd1, 64'h100, 1'b0}, 1'b1);

        // Latency extremes
        single_fetch(1, 64'h600, 3, "lat1", '{32'h0001_22B7, 3'b100, 5'd2, 5'd0, 5'd5, 64'h600, 1'b0}, 1'b0);
        check("lat1_type", itype[1], 3'b100);
        single_fetch(2, 64'h600, 17, "lat15", '{32'h0001_22B7, 3'b100, 5'd2, 5'd0, 5'd5, 64'h600, 1'b0}, 1'b0);
        check("lat15_rd", rd[2], 5'd5);

        repeat (3) step();
        check("mem_rd_pulses", rd_pulses, 9);
        check("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_fetch_decode.md
INSTR_FETCH_DECODE -- requirements
Module: instr_fetch_decode

Interface
REQ-001 SHALL have parameter MEM_LATENCY, default 2, meaning cycles from mem_rd to valid mem_data (legal 1..15).
REQ-002 SHALL have port clock  in  1  sole clock, rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port fetch_req  in  1  request fetch of instruction at pc.
REQ-005 SHALL have port pc  in  64  fetch address, sampled with fetch_req.
REQ-006 SHALL have port flush  in  1  abort any fetch; drop held instruction.
REQ-007 SHALL have port mem_rd  out  1  one-cycle memory read strobe.
REQ-008 SHALL have port mem_addr  out  64  read address, held from issue until next issue.
REQ-009 SHALL have port mem_data  in  32  instruction word from memory.
REQ-010 SHALL have port out_valid  out  1  decoded instruction available.
REQ-011 SHALL have port out_ready  in  1  downstream (immediate extender/execute) accepts.
REQ-012 SHALL have port Instr31_0  out  32  captured instruction word.
REQ-013 SHALL have port InstrType  out  3  immediate format for the sign extender.
REQ-014 SHALL have ports rs1, rs2, rd  out  5 each  register fields [19:15], [24:20], [11:7].
REQ-015 SHALL have port out_pc  out  64  address of held instruction.
REQ-016 SHALL have port illegal  out  1  opcode not in decode table.
REQ-017 SHALL have port fetch_busy  out  1  high whenever state is not IDLE.

Function
REQ-018 SHALL implement FSM states IDLE, ISSUE, WAIT, VALID.
REQ-019 IDLE: fetch_req=1 and flush=0 -> ISSUE; mem_addr and out_pc load pc at that edge.
REQ-020 ISSUE: mem_rd=1 for exactly this cycle; load 4-bit counter with MEM_LATENCY; -> WAIT.
REQ-021 WAIT: counter decrements each cycle; Instr31_0 captures mem_data at the edge where counter equals 1; -> VALID.
REQ-022 Latency: fetch_req high in cycle 0 -> mem_rd in cycle 1 -> capture at end of cycle 1+MEM_LATENCY -> out_valid from cycle 2+MEM_LATENCY.
REQ-023 VALID: out_valid=1; Instr31_0, InstrType, rs1, rs2, rd, out_pc, illegal stable until handshake (out_valid & out_ready).
REQ-024 VALID handshake with fetch_req=1 -> ISSUE with new pc (back-to-back, no IDLE cycle); handshake with fetch_req=0 -> IDLE.
REQ-025 fetch_req SHALL be ignored in ISSUE, WAIT, and VALID without handshake.
REQ-026 flush=1 in any state -> IDLE next edge, out_valid=0, captured data discarded; flush wins over simultaneous fetch_req and handshake.
REQ-027 Decode from Instr31_0[6:0]: 0000011, 0010011, 0011011, 1100111, 1110011 -> 3'b000 (I); 0100011 -> 3'b001 (S); 1100011 -> 3'b010 (SB); 1101111 -> 3'b011 (UJ); 0110111, 0010111 -> 3'b100 (U); 0110011, 0111011 -> 3'b111 (R, no immediate).
REQ-028 Any other opcode -> InstrType 3'b111, illegal=1; still presented and handshaken normally.
REQ-029 InstrType, register fields and illegal SHALL be registered alongside Instr31_0, never combinational from mem_data.
REQ-030 Counter SHALL never wrap: it leaves WAIT at 1 and is reloaded only in ISSUE.

Reset
REQ-031 reset=1 SHALL asynchronously force IDLE, counter 0, and all outputs to 0 (InstrType 3'b000, illegal 0, mem_addr and out_pc 0).
REQ-032 Reset mid-fetch SHALL abandon the fetch; no mem_rd or out_valid after release until a new fetch_req.
REQ-033 First fetch_req SHALL be accepted on the first rising edge after reset deasserts.

Verification
REQ-034 MEM_LATENCY=2, pc=0x100, fetch_req cycle 0, mem_data=0xFFF10093 -> mem_rd cycle 1, mem_addr=0x100, out_valid cycle 4, InstrType 000, rd=1, rs1=2, out_pc=0x100.
REQ-035 Back-to-back: 0x00512423 then 0x00208463 with out_ready=1 and fetch_req held -> InstrType 001 (rs1=2, rs2=5) then 010; second mem_rd in the handshake cycle +1.
REQ-036 Backpressure: 0x008000EF, out_ready=0 for 5 cycles -> out_valid and InstrType 011, rd=1 held; fetch_req ignored; single handshake on out_ready.
REQ-037 Illegal/U: 0x0000007F -> illegal=1, InstrType 111; 0x000122B7 -> InstrType 100, rd=5, illegal=0.
REQ-038 flush in WAIT -> IDLE next cycle, no out_valid; reset asserted in VALID -> out_valid=0 immediately, all outputs 0.
REQ-039 MEM_LATENCY=1 and 15 -> out_valid exactly cycle 3 and cycle 17 after fetch_req.
